// File: rtl/zap_mem_pkg.sv
// Shared encodings for the buffered memory stage: access sizes, exception
// vector bit positions and fixed entry field widths.
package zap_mem_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_LO_W = 2;
    localparam int EXC_W   = 6;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_WORD_ALT = 2'd3
    } size_e;

    // Exception vector layout: {dabt, und, iabt, swi, fiq, irq}.
    localparam int EXC_IRQ  = 0;
    localparam int EXC_FIQ  = 1;
    localparam int EXC_SWI  = 2;
    localparam int EXC_IABT = 3;
    localparam int EXC_UND  = 4;
    localparam int EXC_DABT = 5;

endpackage

// File: rtl/zap_load_formatter.sv
// Combinational load-data formatter: lane extraction, sign extension,
// unaligned word rotation and alignment-fault detection.
module zap_load_formatter
    import zap_mem_pkg::*;
(
    input  logic [DATA_W-1:0]    i_data,
    input  logic [DATA_W-1:0]    i_passthru,
    input  logic [ADDR_LO_W-1:0] i_addr,
    input  logic [1:0]           i_size,
    input  logic                 i_signed,
    input  logic                 i_big_endian,
    input  logic                 i_align_check,
    input  logic                 i_load,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_fault
);

    logic [1:0]  byte_lane;
    logic        half_sel;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] rot_val;

    always_comb begin
        byte_lane = i_addr ^ {2{i_big_endian}};
        half_sel  = i_addr[1] ^ i_big_endian;

        case (byte_lane)
            2'd0:    byte_val = i_data[7:0];
            2'd1:    byte_val = i_data[15:8];
            2'd2:    byte_val = i_data[23:16];
            default: byte_val = i_data[31:24];
        endcase

        half_val = half_sel ? i_data[31:16] : i_data[15:0];

        // ARM-style rotate right by 8 * addr for unaligned word loads.
        case (i_addr)
            2'd1:    rot_val = {i_data[7:0],  i_data[31:8]};
            2'd2:    rot_val = {i_data[15:0], i_data[31:16]};
            2'd3:    rot_val = {i_data[23:0], i_data[31:24]};
            default: rot_val = i_data;
        endcase

        o_data  = i_passthru;
        o_fault = 1'b0;

        if (i_load) begin
            case (size_e'(i_size))
                SZ_BYTE: begin
                    o_data = {{24{i_signed & byte_val[7]}}, byte_val};
                end
                SZ_HALF: begin
                    if (i_addr[0] && i_align_check) begin
                        o_data  = '0;
                        o_fault = 1'b1;
                    end else begin
                        o_data = {{16{i_signed & half_val[15]}}, half_val};
                    end
                end
                default: begin
                    if (i_addr == 2'd0) begin
                        o_data = i_data;
                    end else if (i_align_check) begin
                        o_data  = '0;
                        o_fault = 1'b1;
                    end else begin
                        o_data = rot_val;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/zap_memory_stage_buffered.sv
// Memory stage: formats load data on entry, then queues complete results in a
// DEPTH-entry FIFO with valid/ready on both sides.
module zap_memory_stage_buffered
    import zap_mem_pkg::*;
#(
    parameter  int FLAG_WDT = 32,
    parameter  int PHY_REGS = 46,
    parameter  int DEPTH    = 2,
    localparam int IW       = $clog2(PHY_REGS),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,

    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_load,
    input  logic [1:0]           i_addr,
    input  logic [1:0]           i_size,
    input  logic                 i_signed,
    input  logic                 i_big_endian,
    input  logic                 i_align_check,
    input  logic [31:0]          i_rd_data,
    input  logic [31:0]          i_srcdest_value,
    input  logic [31:0]          i_alu_result,
    input  logic [FLAG_WDT-1:0]  i_flags,
    input  logic [IW-1:0]        i_dest_index,
    input  logic [IW-1:0]        i_srcdest_index,
    input  logic [31:0]          i_pc_plus_8,
    input  logic [5:0]           i_exc,

    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_alu_result,
    output logic [FLAG_WDT-1:0]  o_flags,
    output logic [IW-1:0]        o_dest_index,
    output logic [IW-1:0]        o_srcdest_index,
    output logic [31:0]          o_pc_plus_8,
    output logic [5:0]           o_exc,
    output logic                 o_load,
    output logic [31:0]          o_rd_data,
    output logic                 o_align_fault,
    output logic [CW-1:0]        o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0]   rd_data;
        logic [31:0]         alu_result;
        logic [FLAG_WDT-1:0] flags;
        logic [IW-1:0]       dest_index;
        logic [IW-1:0]       srcdest_index;
        logic [31:0]         pc_plus_8;
        logic [EXC_W-1:0]    exc;
        logic                load;
        logic                align_fault;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [DATA_W-1:0] fmt_data;
    logic              fmt_fault;
    entry_t            in_entry;
    entry_t            head;
    logic [PW-1:0]     show_ptr;
    logic              push;
    logic              pop;

    zap_load_formatter u_fmt (
        .i_data        (i_rd_data),
        .i_passthru    (i_srcdest_value),
        .i_addr        (i_addr),
        .i_size        (i_size),
        .i_signed      (i_signed),
        .i_big_endian  (i_big_endian),
        .i_align_check (i_align_check),
        .i_load        (i_load),
        .o_data        (fmt_data),
        .o_fault       (fmt_fault)
    );

    // Handshake: an entry moves on a side exactly when that side's valid and
    // ready are both high at the rising edge; ready never depends on valid.
    assign o_ready = (count_q < DEPTH_C);
    assign o_valid = (count_q != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        in_entry.rd_data       = fmt_data;
        in_entry.alu_result    = i_alu_result;
        in_entry.flags         = i_flags;
        in_entry.dest_index    = i_dest_index;
        in_entry.srcdest_index = i_srcdest_index;
        in_entry.pc_plus_8     = i_pc_plus_8;
        in_entry.exc           = i_exc;
        in_entry.load          = i_load;
        in_entry.align_fault   = fmt_fault;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Clear empties the queue by catching the read pointer up to the write
        // pointer, so the last written entry remains the held output.
        if (i_clear) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // When empty, present the most recently popped entry so fields hold.
    always_comb begin
        show_ptr = (count_q == '0) ? (rd_ptr_q - PW'(1)) : rd_ptr_q;
        head     = mem_q[show_ptr];
    end

    assign o_rd_data       = head.rd_data;
    assign o_alu_result    = head.alu_result;
    assign o_flags         = head.flags;
    assign o_dest_index    = head.dest_index;
    assign o_srcdest_index = head.srcdest_index;
    assign o_pc_plus_8     = head.pc_plus_8;
    assign o_exc           = head.exc;
    assign o_load          = head.load;
    assign o_align_fault   = head.align_fault;
    assign o_count         = count_q;

endmodule

// File: tb/tb_zap_memory_stage_buffered.sv
// Directed bench for zap_memory_stage_buffered: load formatting vectors,
// back-pressure, clear and reset behaviour with DEPTH=2.
module tb_zap_memory_stage_buffered;

    localparam int FLAG_WDT = 32;
    localparam int PHY_REGS = 46;
    localparam int DEPTH    = 2;
    localparam int IW       = $clog2(PHY_REGS);
    localparam int CW       = $clog2(DEPTH) + 1;

    logic                i_clk = 1'b0;
    logic                i_reset, i_clear, i_valid, o_ready;
    logic                i_load, i_signed, i_big_endian, i_align_check;
    logic [1:0]          i_addr, i_size;
    logic [31:0]         i_rd_data, i_srcdest_value, i_alu_result, i_pc_plus_8;
    logic [FLAG_WDT-1:0] i_flags;
    logic [IW-1:0]       i_dest_index, i_srcdest_index;
    logic [5:0]          i_exc;
    logic                o_valid, i_ready;
    logic [31:0]         o_alu_result, o_pc_plus_8, o_rd_data;
    logic [FLAG_WDT-1:0] o_flags;
    logic [IW-1:0]       o_dest_index, o_srcdest_index;
    logic [5:0]          o_exc;
    logic                o_load, o_align_fault;
    logic [CW-1:0]       o_count;

    int errors = 0;
    int checks = 0;

    zap_memory_stage_buffered #(
        .FLAG_WDT (FLAG_WDT),
        .PHY_REGS (PHY_REGS),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (i_clear),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_load          (i_load),
        .i_addr          (i_addr),
        .i_size          (i_size),
        .i_signed        (i_signed),
        .i_big_endian    (i_big_endian),
        .i_align_check   (i_align_check),
        .i_rd_data       (i_rd_data),
        .i_srcdest_value (i_srcdest_value),
        .i_alu_result    (i_alu_result),
        .i_flags         (i_flags),
        .i_dest_index    (i_dest_index),
        .i_srcdest_index (i_srcdest_index),
        .i_pc_plus_8     (i_pc_plus_8),
        .i_exc           (i_exc),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_alu_result    (o_alu_result),
        .o_flags         (o_flags),
        .o_dest_index    (o_dest_index),
        .o_srcdest_index (o_srcdest_index),
        .o_pc_plus_8     (o_pc_plus_8),
        .o_exc           (o_exc),
        .o_load          (o_load),
        .o_rd_data       (o_rd_data),
        .o_align_fault   (o_align_fault),
        .o_count         (o_count)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic load, input logic [1:0] addr, input logic [1:0] size,
                         input logic sgn, input logic be, input logic ac,
                         input logic [31:0] rd, input logic [31:0] sv);
        i_valid         = 1'b1;
        i_load          = load;
        i_addr          = addr;
        i_size          = size;
        i_signed        = sgn;
        i_big_endian    = be;
        i_align_check   = ac;
        i_rd_data       = rd;
        i_srcdest_value = sv;
    endtask

    // Push one load with i_ready high; the head after the edge is this entry.
    task automatic load_chk(input string tag, input logic [1:0] addr, input logic [1:0] size,
                            input logic sgn, input logic be, input logic ac,
                            input logic [31:0] rd, input logic [31:0] exp_data,
                            input logic exp_fault);
        drive(1'b1, addr, size, sgn, be, ac, rd, 32'h0BAD_0BAD);
        step();
        i_valid = 1'b0;
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_data"}, o_rd_data, exp_data);
        chk({tag, "_fault"}, 32'(o_align_fault), 32'(exp_fault));
    endtask

    initial begin
        i_reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_load = 1'b0; i_addr = 2'd0; i_size = 2'd0; i_signed = 1'b0;
        i_big_endian = 1'b0; i_align_check = 1'b0;
        i_rd_data = '0; i_srcdest_value = '0; i_alu_result = '0;
        i_flags = '0; i_dest_index = '0; i_srcdest_index = '0;
        i_pc_plus_8 = '0; i_exc = '0;
        step();
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_exc", 32'(o_exc), 32'd0);
        chk("rst_fault", 32'(o_align_fault), 32'd0);
        chk("rst_load", 32'(o_load), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        i_reset = 1'b0;
        step();

        // Little-endian byte loads, signed and unsigned.
        load_chk("le_b0", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h80FF7F01, 32'h00000001, 1'b0);
        chk("le_b0_count", 32'(o_count), 32'd1);
        load_chk("le_b1", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h80FF7F01, 32'h0000007F, 1'b0);
        load_chk("le_b2", 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0);
        load_chk("le_b3", 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 32'h80FF7F01, 32'hFFFFFF80, 1'b0);
        chk("le_b3_load", 32'(o_load), 32'd1);
        load_chk("le_b3u", 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 32'h80FF7F01, 32'h00000080, 1'b0);
        load_chk("be_b0", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h80FF7F01, 32'h00000080, 1'b0);

        // Halfword loads, both endiannesses, plus a misaligned halfword.
        load_chk("be_h0", 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 32'h80011234, 32'hFFFF8001, 1'b0);
        load_chk("le_h0", 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 32'h80011234, 32'h00001234, 1'b0);
        load_chk("le_h2u", 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 32'h80011234, 32'h00008001, 1'b0);
        load_chk("h_mis", 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h80011234, 32'h00000000, 1'b1);

        // Word loads: aligned, rotated, faulted, and size 3 treated as word.
        load_chk("w_al", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0);
        load_chk("w_rot1", 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hAABBCCDD, 32'hDDAABBCC, 1'b0);
        load_chk("w_flt1", 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 32'h00000000, 1'b1);
        load_chk("w3_rot2", 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 32'hAABBCCDD, 32'hCCDDAABB, 1'b0);
        step();
        chk("drain_valid", 32'(o_valid), 32'd0);
        chk("drain_count", 32'(o_count), 32'd0);

        // Non-load passthrough with sideband fields.
        drive(1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678);
        i_alu_result = 32'hDEADBEEF; i_flags = 32'hF0000010;
        i_dest_index = 6'd45; i_srcdest_index = 6'd7;
        i_pc_plus_8 = 32'h00001008; i_exc = 6'b101010;
        step();
        i_valid = 1'b0;
        chk("nl_valid", 32'(o_valid), 32'd1);
        chk("nl_data", o_rd_data, 32'h12345678);
        chk("nl_fault", 32'(o_align_fault), 32'd0);
        chk("nl_load", 32'(o_load), 32'd0);
        chk("nl_exc", 32'(o_exc), 32'h2A);
        chk("nl_dest", 32'(o_dest_index), 32'd45);
        chk("nl_srcdest", 32'(o_srcdest_index), 32'd7);
        chk("nl_alu", o_alu_result, 32'hDEADBEEF);
        chk("nl_flags", o_flags, 32'hF0000010);
        chk("nl_pc", o_pc_plus_8, 32'h00001008);
        i_exc = 6'b000000;
        step();

        // Back-pressure: three offered, two accepted, drained in order.
        i_ready = 1'b0;
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h11111111);
        step();
        chk("bp_cnt1", 32'(o_count), 32'd1);
        chk("bp_rdy1", 32'(o_ready), 32'd1);
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h22222222);
        step();
        chk("bp_cnt2", 32'(o_count), 32'd2);
        chk("bp_rdy2", 32'(o_ready), 32'd0);
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h33333333);
        step();
        chk("bp_held_cnt", 32'(o_count), 32'd2);
        chk("bp_head_a", o_rd_data, 32'h11111111);
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("bp_pop_cnt1", 32'(o_count), 32'd1);
        chk("bp_head_b", o_rd_data, 32'h22222222);
        step();
        chk("bp_pop_cnt0", 32'(o_count), 32'd0);
        chk("bp_empty_valid", 32'(o_valid), 32'd0);
        chk("bp_hold_last", o_rd_data, 32'h22222222);
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h33333333);
        step();
        i_valid = 1'b0;
        chk("bp_head_c", o_rd_data, 32'h33333333);
        step();

        // Clear on a full FIFO with simultaneous push and pop.
        i_ready = 1'b0;
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44444444);
        step();
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h55555555);
        step();
        chk("clr_full", 32'(o_count), 32'd2);
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h66666666);
        i_ready = 1'b1;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("clr_valid", 32'(o_valid), 32'd0);
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_ready", 32'(o_ready), 32'd1);
        step();
        chk("clr_noleak_valid", 32'(o_valid), 32'd0);
        chk("clr_noleak_count", 32'(o_count), 32'd0);

        // Reset mid-operation.
        i_ready = 1'b0;
        drive(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h77777777);
        i_exc = 6'b111111;
        step();
        chk("mid_cnt", 32'(o_count), 32'd1);
        i_valid = 1'b0;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        chk("mid_rst_exc", 32'(o_exc), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
